// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit with its sequencing FSM, for the EX stage.
// One operation is accepted from IDLE. It then iterates for 32 cycles, one bit per
// cycle, and presents a registered result for a single DONE cycle.
//
// Ports:
//   clock        - system clock, rising edge
//   reset        - synchronous, active-high reset
//   start        - ID/EX holds a valid M-extension instruction
//   funct3       - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                  100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a, op_b   - rs1/rs2 values after forwarding
//   reg_rd_in    - destination register of the request
//   flush        - kill any in-flight operation
//   stall        - freeze PC, IF/ID and ID/EX
//   busy         - FSM is not IDLE
//   result_valid - result/reg_rd_out are valid this cycle
//   result       - operation result; held until the next completion
//   reg_rd_out   - destination register of the result
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      reg_rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      reg_rd_out
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  // Multiply: {product_hi, multiplier}; divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       divr_q, divr_d;   // multiplicand or divisor magnitude
  logic [2:0]            f3_q, f3_d;
  logic [4:0]            rd_q, rd_d;
  logic                  sa_q, sa_d;       // dividend / op_a was negative (signed use)
  logic                  neg_q, neg_d;     // operand signs differ
  logic                  bzero_q, bzero_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic [4:0]            rd_out_q, rd_out_d;

  // Request decode and operand magnitudes.
  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (funct3)
      3'b001, 3'b100, 3'b110: begin
        sgn_a = op_a[XLEN-1];
        sgn_b = op_b[XLEN-1];
      end
      3'b010:  sgn_a = op_a[XLEN-1];
      default: ;
    endcase
  end

  assign abs_a = sgn_a ? (~op_a + 1'b1) : op_a;
  assign abs_b = sgn_b ? (~op_b + 1'b1) : op_b;

  // One iteration step of each algorithm.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] step_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, divr_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring division: trial-subtract the divisor from the shifted remainder.
  assign div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, divr_q};
  assign div_next = div_diff[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  assign step_next = f3_q[2] ? div_next : mul_next;

  // Sign fixups applied to the final step.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  assign prod_fix = neg_q ? (~step_next + 1'b1) : step_next;
  assign quo_fix  = bzero_q ? '1
                  : (neg_q ? (~step_next[XLEN-1:0] + 1'b1) : step_next[XLEN-1:0]);
  assign rem_fix  = sa_q ? (~step_next[2*XLEN-1:XLEN] + 1'b1) : step_next[2*XLEN-1:XLEN];

  always_comb begin
    final_res = '0;
    unique case (f3_q)
      3'b000:                 final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_fix;
      default:                final_res = rem_fix;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    divr_d   = divr_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    sa_d     = sa_q;
    neg_d    = neg_q;
    bzero_d  = bzero_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          f3_d    = funct3;
          rd_d    = reg_rd_in;
          sa_d    = sgn_a;
          neg_d   = sgn_a ^ sgn_b;
          bzero_d = (op_b == '0);
          acc_d   = {{XLEN{1'b0}}, abs_a};
          divr_d  = abs_b;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = step_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(XLEN - 1)) begin
            result_d = final_res;
            rd_out_d = rd_q;
            state_d  = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      divr_q   <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      sa_q     <= 1'b0;
      neg_q    <= 1'b0;
      bzero_q  <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      divr_q   <= divr_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      sa_q     <= sa_d;
      neg_q    <= neg_d;
      bzero_q  <= bzero_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign stall        = ((state_q == StIdle) && start && !flush) || (state_q == StCalc);
  assign busy         = (state_q != StIdle);
  assign result_valid = (state_q == StDone);
  assign result       = result_q;
  assign reg_rd_out   = rd_out_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  reg_rd_in = '0;
  logic        flush = 1'b0;
  logic        stall, busy, result_valid;
  logic [31:0] result;
  logic [4:0]  reg_rd_out;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .funct3       (funct3),
    .op_a         (op_a),
    .op_b         (op_b),
    .reg_rd_in    (reg_rd_in),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .reg_rd_out   (reg_rd_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and watch 40 cycles. With noise set, start is pulsed
  // with other operands during CALC and during DONE; both must be ignored.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input bit noise);
    int          stall_n = 0;
    int          valid_n = 0;
    int          valid_at = -1;
    logic [31:0] res = '0;
    logic [4:0]  rdo = '0;
    logic        busy_v = 1'b0;
    @(negedge clock);
    funct3 = f; op_a = a; op_b = b; reg_rd_in = rd; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall) stall_n++;
      if (result_valid) begin
        valid_n++; valid_at = i; res = result; rdo = reg_rd_out; busy_v = busy;
      end
      @(negedge clock);
      if (noise && (i == 4 || i == 32)) begin
        start = 1'b1; funct3 = 3'b000; op_a = 32'h1234; op_b = 32'h5; reg_rd_in = 5'd31;
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, " stall_cycles"}, stall_n, 33);
    chk({tag, " valid_cycles"}, valid_n, 1);
    chk({tag, " valid_at"}, valid_at, 33);
    chk({tag, " result"}, res, exp);
    chk({tag, " rd"}, {27'd0, rdo}, {27'd0, rd});
    chk({tag, " busy_in_done"}, {31'd0, busy_v}, 32'd1);
  endtask

  initial begin
    int vseen;
    // Reset state.
    repeat (2) @(negedge clock);
    #1;
    chk("rst result", result, 32'h0);
    chk("rst rd", {27'd0, reg_rd_out}, 32'h0);
    chk("rst busy", {31'd0, busy}, 32'h0);
    chk("rst valid", {31'd0, result_valid}, 32'h0);
    chk("rst stall", {31'd0, stall}, 32'h0);
    reset = 1'b0;

    run_op("MUL",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b1);
    run_op("MULH",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0);
    run_op("MULHU",  3'b011, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, 1'b0);
    run_op("MULHSU", 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'hC000_0000, 1'b0);
    run_op("DIV",    3'b100, 32'hFFFF_FFEC, 32'd3,         5'd10, 32'hFFFF_FFFA, 1'b0);
    run_op("REM",    3'b110, 32'hFFFF_FFEC, 32'd3,         5'd11, 32'hFFFF_FFFE, 1'b0);
    run_op("DIVU",   3'b101, 32'hFFFF_FFEC, 32'd3,         5'd12, 32'h5555_554E, 1'b0);

    // Flush in the 10th CALC cycle: no result, previous result/rd kept.
    @(negedge clock);
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4; reg_rd_in = 5'd9; start = 1'b1;
    #1 chk("flush start stall", {31'd0, stall}, 32'd1);
    vseen = 0;
    @(negedge clock);
    start = 1'b0;
    repeat (9) begin
      #1 if (result_valid) vseen++;
      @(negedge clock);
    end
    flush = 1'b1;
    #1 if (result_valid) vseen++;
    @(negedge clock);
    flush = 1'b0;
    #1;
    chk("flush no valid", vseen, 0);
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush stall", {31'd0, stall}, 32'd0);
    chk("flush result held", result, 32'h5555_554E);
    chk("flush rd held", {27'd0, reg_rd_out}, 32'd12);

    run_op("DIVU0", 3'b101, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1'b0);
    run_op("REMU0", 3'b111, 32'd5,         32'd0,         5'd14, 32'd5,         1'b0);
    run_op("DIVOV", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b0);

    // Reset mid-CALC clears everything.
    @(negedge clock);
    funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; reg_rd_in = 5'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst result", result, 32'h0);
    chk("midrst rd", {27'd0, reg_rd_out}, 32'h0);
    chk("midrst busy", {31'd0, busy}, 32'h0);
    chk("midrst valid", {31'd0, result_valid}, 32'h0);
    chk("midrst stall", {31'd0, stall}, 32'h0);

    run_op("REMOV", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0, 1'b0);

    // start and flush together in IDLE: nothing accepted.
    @(negedge clock);
    funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; reg_rd_in = 5'd4;
    start = 1'b1; flush = 1'b1;
    #1 chk("sf stall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("sf busy", {31'd0, busy}, 32'd0);
    chk("sf stall after", {31'd0, stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit plus its sequencing FSM, for the RV32M instructions executed in the EX stage.
- Accepts one operation per request, using the operands produced after the forwarding muxes.
- Holds the pipeline stall line while it iterates (32 iterations), then presents a registered result for exactly one cycle, together with the destination register, to the EX/MEM register.
- Latency is deterministic for every opcode and operand value.

Parameters:
- XLEN, 32: operand/result width. Only 32 is supported; the iteration counter is 5 bits, derived as log2(XLEN).

Ports:
- clock  input  1  system clock; every register updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  ID/EX holds a valid M-extension instruction.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  32  rs1 value after forwarding.
- op_b  input  32  rs2 value after forwarding.
- reg_rd_in  input  5  destination register.
- flush  input  1  kill the in-flight operation (branch taken / pipeline flush).
- stall  output  1  freeze PC, IF/ID and ID/EX.
- busy  output  1  FSM is not IDLE.
- result_valid  output  1  result is valid this cycle.
- result  output  32  operation result.
- reg_rd_out  output  5  destination register of the result.

Behaviour:
- Reset: synchronous, active-high, clock edge sampled with reset=1. Outputs after reset:
  - FSM goes to IDLE.
  - result=0, reg_rd_out=0, result_valid=0, busy=0.
  - Counter and internal accumulators cleared.
- stall is combinational: (IDLE & start & ~flush) | CALC. stall is 0 in DONE, so the pipeline advances and captures the result.
- IDLE:
  - busy=0.
  - start=1 and flush=0 at edge k: latch funct3 and rd, and record the sign flags.
  - Load |op_a| and |op_b|. Take magnitudes only for the signed operand(s) of MULH, MULHSU (op_a only), DIV and REM. MUL uses raw operands, since the low word is sign-agnostic.
  - Then counter=0 and go to CALC.
- CALC:
  - One iteration per edge, edges k+1 .. k+32; counter increments.
  - Multiply: radix-2 shift-add into a 64-bit product.
  - Divide: restoring shift-subtract giving a 32-bit quotient and remainder.
  - At edge k+32 (counter==31): apply the fixups below, register result, go to DONE.
- Fixups (applied in the k+32 update):
  - Multiply: negate the 64-bit product if the sign flags differ. MUL returns bits[31:0]; MULH, MULHSU and MULHU return bits[63:32].
  - Quotient: negated if the dividend and divisor signs differ (signed ops).
  - Remainder: carries the dividend's sign.
  - Divide by zero (all divide ops): quotient=0xFFFFFFFF, remainder=op_a. Latency is unchanged.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV=0x80000000, REM=0.
- DONE:
  - Occupies the single cycle between edges k+32 and k+33.
  - result_valid=1, busy=1, stall=0; reg_rd_out = latched rd.
  - Next edge goes to IDLE.
  - start during DONE is ignored; the pipeline has not yet advanced the new instruction.
- Timing summary:
  - stall is high for exactly 33 consecutive cycles (the start cycle plus 32 CALC cycles).
  - result_valid is high for exactly 1 cycle.
  - The next start is accepted no earlier than edge k+34.
- result and reg_rd_out hold their values after DONE until the next completion or reset. result_valid=0 outside DONE.
- flush:
  - In any state, flush=1 forces IDLE at the next edge. No result_valid is produced; result and reg_rd_out are unchanged.
  - start and flush together in IDLE: flush wins, stall=0, nothing is accepted.
- reset mid-operation behaves like flush, but also clears result and reg_rd_out.
- start while busy (CALC) is ignored; the operands are not resampled.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3), rd=5 -> stall high 33 cycles; result_valid for 1 cycle with result=0xFFFFFFEB, reg_rd_out=5.
- MULH / MULHU / MULHSU, op_a=op_b=0x80000000 -> MULH=0x40000000, MULHU=0x40000000, MULHSU=0xC0000000.
- Signed divide, op_a=0xFFFFFFEC (-20), op_b=3:
  - DIV -> 0xFFFFFFFA.
  - REM -> 0xFFFFFFFE.
  - DIVU with the same operands -> 0x5555554E.
- Corner cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
  - Each corner case takes the full 33-cycle latency.
- Kill and restart:
  - Start MUL, assert flush in the 10th CALC cycle -> IDLE next edge, stall drops, no result_valid, result still holds the previous value.
  - A new start 1 cycle later is accepted and completes normally.
- Start rules:
  - reset asserted mid-CALC -> all outputs return to their reset values.
  - start+flush together in IDLE -> stall=0, busy stays 0.
  - start pulsed during CALC/DONE -> ignored; the first result is unaffected.
